// File: rtl/branch_target_pkg.sv
// Shared encodings and helpers for the set-associative branch target buffer.
package branch_target_pkg;

  // Widest address and counter the helpers accept; callers cast to their own widths.
  localparam int unsigned ADDR_MAX_W = 64;
  localparam int unsigned CNT_MAX_W  = 8;

  // Direction counter encodings for the default 2-bit counter.
  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] WEAK_T    = 2'b10;
  localparam logic [1:0] STRONG_T  = 2'b11;

  // Set index: word-aligned address bits just above the byte offset.
  function automatic logic [ADDR_MAX_W-1:0] addr_index(input logic [ADDR_MAX_W-1:0] addr,
                                                       input int unsigned index_bits);
    logic [ADDR_MAX_W-1:0] mask;
    mask = (ADDR_MAX_W'(1) << index_bits) - ADDR_MAX_W'(1);
    return (addr >> 2) & mask;
  endfunction

  // Tag: everything above the set index.
  function automatic logic [ADDR_MAX_W-1:0] addr_tag(input logic [ADDR_MAX_W-1:0] addr,
                                                     input int unsigned index_bits);
    return addr >> (index_bits + 2);
  endfunction

  // Freshly allocated entries start weakly taken: MSB set, all other bits clear.
  function automatic logic [CNT_MAX_W-1:0] cnt_weak_taken(input int unsigned bits);
    return CNT_MAX_W'(CNT_MAX_W'(1) << (bits - 1));
  endfunction

  // Saturating increment at 2^bits-1.
  function automatic logic [CNT_MAX_W-1:0] cnt_sat_inc(input logic [CNT_MAX_W-1:0] c,
                                                       input int unsigned bits);
    logic [CNT_MAX_W-1:0] max;
    max = CNT_MAX_W'((16'(1) << bits) - 16'(1));
    return (c >= max) ? c : c + CNT_MAX_W'(1);
  endfunction

  // Saturating decrement at 0.
  function automatic logic [CNT_MAX_W-1:0] cnt_sat_dec(input logic [CNT_MAX_W-1:0] c);
    return (c == '0) ? c : c - CNT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/btb_way.sv
// One way of the BTB: per-set valid/tag/target/counter with two combinational
// read ports (fetch lookup, Ex training) and a single write port at the Ex index.
module btb_way #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INDEX_BITS = 3,
  parameter int unsigned CNT_BITS   = 2,
  parameter int unsigned TAG_BITS   = DATA_WIDTH - 2 - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [INDEX_BITS-1:0] lk_idx,
  output logic                  lk_valid_c,
  output logic [TAG_BITS-1:0]   lk_tag_c,
  output logic [DATA_WIDTH-1:0] lk_target_c,
  output logic                  lk_taken_c,
  input  logic [INDEX_BITS-1:0] ex_idx,
  output logic                  ex_valid_c,
  output logic [TAG_BITS-1:0]   ex_tag_c,
  output logic [DATA_WIDTH-1:0] ex_target_c,
  output logic [CNT_BITS-1:0]   ex_cnt_c,
  input  logic                  we,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_target,
  input  logic [CNT_BITS-1:0]   wr_cnt
);

  localparam int unsigned SETS = 1 << INDEX_BITS;

  logic [SETS-1:0]       valid_q;
  logic [TAG_BITS-1:0]   tag_q    [SETS];
  logic [DATA_WIDTH-1:0] target_q [SETS];
  logic [CNT_BITS-1:0]   cnt_q    [SETS];

  // Storage: async clear, flush drops valid only, otherwise single-entry write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        tag_q[s]    <= '0;
        target_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[ex_idx]  <= 1'b1;
      tag_q[ex_idx]    <= wr_tag;
      target_q[ex_idx] <= wr_target;
      cnt_q[ex_idx]    <= wr_cnt;
    end
  end

  // Combinational read ports.
  always_comb begin
    lk_valid_c  = valid_q[lk_idx];
    lk_tag_c    = tag_q[lk_idx];
    lk_target_c = target_q[lk_idx];
    lk_taken_c  = cnt_q[lk_idx][CNT_BITS-1];
    ex_valid_c  = valid_q[ex_idx];
    ex_tag_c    = tag_q[ex_idx];
    ex_target_c = target_q[ex_idx];
    ex_cnt_c    = cnt_q[ex_idx];
  end

endmodule

// File: rtl/branch_target_assoc.sv
// N-way set-associative BTB with saturating direction counters and a
// per-set round-robin victim pointer. Lookup is same-cycle; training lands
// at the next edge.
module branch_target_assoc
  import branch_target_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INDEX_BITS = 3,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned CNT_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] PC,
  output logic                  Hit,
  output logic                  Pred_Taken,
  output logic [DATA_WIDTH-1:0] Target_Add,
  input  logic [DATA_WIDTH-1:0] PC_Ex,
  input  logic [DATA_WIDTH-1:0] PC_ALU,
  input  logic                  Br_Detected,
  input  logic                  Br_Taken,
  input  logic                  Stall_Detected,
  input  logic                  Flush
);

  localparam int unsigned TAG_BITS = DATA_WIDTH - 2 - INDEX_BITS;
  localparam int unsigned SETS     = 1 << INDEX_BITS;
  localparam int unsigned WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [INDEX_BITS-1:0] lk_idx, ex_idx;
  logic [TAG_BITS-1:0]   lk_tag, ex_tag;

  logic [WAYS-1:0]       lk_valid, lk_taken, ex_valid, way_we;
  logic [TAG_BITS-1:0]   lk_tag_rd    [WAYS];
  logic [DATA_WIDTH-1:0] lk_target_rd [WAYS];
  logic [TAG_BITS-1:0]   ex_tag_rd    [WAYS];
  logic [DATA_WIDTH-1:0] ex_target_rd [WAYS];
  logic [CNT_BITS-1:0]   ex_cnt_rd    [WAYS];

  logic [TAG_BITS-1:0]   wr_tag;
  logic [DATA_WIDTH-1:0] wr_target;
  logic [CNT_BITS-1:0]   wr_cnt;

  logic [WAY_BITS-1:0]   ptr_q [SETS];
  logic                  ptr_adv;
  logic [WAY_BITS-1:0]   ptr_next;

  logic                  upd;
  logic                  ex_hit, any_inv;
  logic [WAY_BITS-1:0]   ex_way, inv_way, victim;

  // Address split for both the fetch and the Ex-stage PC.
  always_comb begin
    lk_idx = INDEX_BITS'(addr_index(ADDR_MAX_W'(PC), INDEX_BITS));
    lk_tag = TAG_BITS'(addr_tag(ADDR_MAX_W'(PC), INDEX_BITS));
    ex_idx = INDEX_BITS'(addr_index(ADDR_MAX_W'(PC_Ex), INDEX_BITS));
    ex_tag = TAG_BITS'(addr_tag(ADDR_MAX_W'(PC_Ex), INDEX_BITS));
  end

  for (genvar g = 0; g < int'(WAYS); g++) begin : g_way
    btb_way #(
      .DATA_WIDTH (DATA_WIDTH),
      .INDEX_BITS (INDEX_BITS),
      .CNT_BITS   (CNT_BITS),
      .TAG_BITS   (TAG_BITS)
    ) u_way (
      .clk         (clk),
      .rst         (rst),
      .flush       (Flush),
      .lk_idx      (lk_idx),
      .lk_valid_c  (lk_valid[g]),
      .lk_tag_c    (lk_tag_rd[g]),
      .lk_target_c (lk_target_rd[g]),
      .lk_taken_c  (lk_taken[g]),
      .ex_idx      (ex_idx),
      .ex_valid_c  (ex_valid[g]),
      .ex_tag_c    (ex_tag_rd[g]),
      .ex_target_c (ex_target_rd[g]),
      .ex_cnt_c    (ex_cnt_rd[g]),
      .we          (way_we[g]),
      .wr_tag      (wr_tag),
      .wr_target   (wr_target),
      .wr_cnt      (wr_cnt)
    );
  end

  // Fetch lookup; scanning downward lets the lowest matching way win.
  always_comb begin
    Hit        = 1'b0;
    Pred_Taken = 1'b0;
    Target_Add = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (lk_valid[w] && (lk_tag_rd[w] == lk_tag)) begin
        Hit        = 1'b1;
        Pred_Taken = lk_taken[w];
        Target_Add = lk_target_rd[w];
      end
    end
  end

  // Ex-side match and lowest invalid way in the training set.
  always_comb begin
    ex_hit  = 1'b0;
    ex_way  = '0;
    any_inv = 1'b0;
    inv_way = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (ex_valid[w] && (ex_tag_rd[w] == ex_tag)) begin
        ex_hit = 1'b1;
        ex_way = WAY_BITS'(w);
      end
      if (!ex_valid[w]) begin
        any_inv = 1'b1;
        inv_way = WAY_BITS'(w);
      end
    end
  end

  // Training decision: counter/target update on hit, allocation on taken miss.
  always_comb begin
    upd       = Br_Detected & ~Stall_Detected & ~Flush;
    way_we    = '0;
    wr_tag    = ex_tag;
    wr_target = PC_ALU;
    wr_cnt    = CNT_BITS'(cnt_weak_taken(CNT_BITS));
    ptr_adv   = 1'b0;
    victim    = any_inv ? inv_way : ptr_q[ex_idx];
    ptr_next  = (WAYS == 1) ? '0 : ptr_q[ex_idx] + WAY_BITS'(1);
    if (upd) begin
      if (ex_hit) begin
        way_we[ex_way] = 1'b1;
        if (Br_Taken) begin
          wr_cnt = CNT_BITS'(cnt_sat_inc(CNT_MAX_W'(ex_cnt_rd[ex_way]), CNT_BITS));
        end else begin
          wr_target = ex_target_rd[ex_way];
          wr_cnt    = CNT_BITS'(cnt_sat_dec(CNT_MAX_W'(ex_cnt_rd[ex_way])));
        end
      end else if (Br_Taken) begin
        way_we[victim] = 1'b1;
        ptr_adv        = ~any_inv;
      end
    end
  end

  // Round-robin victim pointers, cleared by reset and flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < int'(SETS); s++) ptr_q[s] <= '0;
    end else if (Flush) begin
      for (int s = 0; s < int'(SETS); s++) ptr_q[s] <= '0;
    end else if (ptr_adv) begin
      ptr_q[ex_idx] <= ptr_next;
    end
  end

endmodule

// File: tb/tb_branch_target_assoc.sv
// Directed bench for branch_target_assoc (default parameters: 32-bit, 8 sets, 2 ways).
module tb_branch_target_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC, PC_Ex, PC_ALU;
  logic        Hit, Pred_Taken;
  logic [31:0] Target_Add;
  logic        Br_Detected, Br_Taken, Stall_Detected, Flush;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] PC_A = 32'h1234_0000;
  localparam logic [31:0] PC_B = 32'h5678_0000;
  localparam logic [31:0] PC_C = 32'h9ABC_0000;
  localparam logic [31:0] PC_D = 32'h0000_0004;

  branch_target_assoc dut (
    .clk            (clk),
    .rst            (rst),
    .PC             (PC),
    .Hit            (Hit),
    .Pred_Taken     (Pred_Taken),
    .Target_Add     (Target_Add),
    .PC_Ex          (PC_Ex),
    .PC_ALU         (PC_ALU),
    .Br_Detected    (Br_Detected),
    .Br_Taken       (Br_Taken),
    .Stall_Detected (Stall_Detected),
    .Flush          (Flush)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic e_hit,
                        input logic e_pt, input logic [31:0] e_tgt);
    PC = pc;
    #1;
    chk({tag, ".hit"}, 32'(Hit), 32'(e_hit));
    chk({tag, ".pt"}, 32'(Pred_Taken), 32'(e_pt));
    chk({tag, ".tgt"}, Target_Add, e_tgt);
  endtask

  task automatic drive(input logic [31:0] pc_ex, input logic [31:0] alu, input logic taken,
                       input logic stall, input logic flush);
    @(negedge clk);
    PC_Ex          = pc_ex;
    PC_ALU         = alu;
    Br_Detected    = 1'b1;
    Br_Taken       = taken;
    Stall_Detected = stall;
    Flush          = flush;
  endtask

  task automatic finish_edge();
    @(posedge clk);
    #1;
    Br_Detected    = 1'b0;
    Br_Taken       = 1'b0;
    Stall_Detected = 1'b0;
    Flush          = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] pc_ex, input logic [31:0] alu, input logic taken,
                         input logic stall, input logic flush);
    drive(pc_ex, alu, taken, stall, flush);
    finish_edge();
  endtask

  initial begin
    rst = 1'b1;
    PC = '0; PC_Ex = '0; PC_ALU = '0;
    Br_Detected = 1'b0; Br_Taken = 1'b0; Stall_Detected = 1'b0; Flush = 1'b0;

    #5;
    lookup("in_reset", PC_A, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    lookup("cold", PC_A, 1'b0, 1'b0, 32'h0);

    // Allocate A; same-cycle lookup still sees the old contents.
    drive(PC_A, 32'hFFFF_AAAA, 1'b1, 1'b0, 1'b0);
    lookup("alloc_a_pre", PC_A, 1'b0, 1'b0, 32'h0);
    finish_edge();
    lookup("alloc_a", PC_A, 1'b1, 1'b1, 32'hFFFF_AAAA);

    // B fills way 1; C evicts way 0 (A) via the round-robin pointer.
    resolve(PC_B, 32'h1111_0000, 1'b1, 1'b0, 1'b0);
    lookup("two_a", PC_A, 1'b1, 1'b1, 32'hFFFF_AAAA);
    lookup("two_b", PC_B, 1'b1, 1'b1, 32'h1111_0000);
    resolve(PC_C, 32'h2222_0000, 1'b1, 1'b0, 1'b0);
    lookup("evict_a", PC_A, 1'b0, 1'b0, 32'h0);
    lookup("evict_b", PC_B, 1'b1, 1'b1, 32'h1111_0000);
    lookup("evict_c", PC_C, 1'b1, 1'b1, 32'h2222_0000);

    // Pointer now at way 1: re-allocating A evicts B.
    resolve(PC_A, 32'hFFFF_AAAA, 1'b1, 1'b0, 1'b0);
    lookup("rr_b", PC_B, 1'b0, 1'b0, 32'h0);
    lookup("rr_a", PC_A, 1'b1, 1'b1, 32'hFFFF_AAAA);
    lookup("rr_c", PC_C, 1'b1, 1'b1, 32'h2222_0000);

    // Counter: 10 -> 01 -> 00 -> 00 (no wrap); target untouched on not-taken.
    resolve(PC_A, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
    lookup("nt1", PC_A, 1'b1, 1'b0, 32'hFFFF_AAAA);
    resolve(PC_A, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
    resolve(PC_A, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
    lookup("nt3", PC_A, 1'b1, 1'b0, 32'hFFFF_AAAA);
    resolve(PC_A, 32'hFFFF_AAAA, 1'b1, 1'b0, 1'b0);
    lookup("t1", PC_A, 1'b1, 1'b0, 32'hFFFF_AAAA);
    resolve(PC_A, 32'hFFFF_AAAA, 1'b1, 1'b0, 1'b0);
    lookup("t2", PC_A, 1'b1, 1'b1, 32'hFFFF_AAAA);
    // 10 -> 11 (new target) -> 11 -> 10: still predicted taken.
    resolve(PC_A, 32'h3333_0000, 1'b1, 1'b0, 1'b0);
    lookup("t3_tgt", PC_A, 1'b1, 1'b1, 32'h3333_0000);
    resolve(PC_A, 32'h3333_0000, 1'b1, 1'b0, 1'b0);
    resolve(PC_A, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    lookup("sat_hi", PC_A, 1'b1, 1'b1, 32'h3333_0000);

    // Another set; offset bits [1:0] are ignored.
    resolve(PC_D, 32'h4444_4444, 1'b1, 1'b0, 1'b0);
    lookup("set1", 32'h0000_0007, 1'b1, 1'b1, 32'h4444_4444);
    lookup("set0_c", PC_C, 1'b1, 1'b1, 32'h2222_0000);

    // Miss plus not-taken leaves no trace.
    resolve(32'h0000_0008, 32'h5555_0000, 1'b0, 1'b0, 1'b0);
    lookup("miss_nt", 32'h0000_0008, 1'b0, 1'b0, 32'h0);

    // Stalled resolutions are dropped.
    resolve(32'h0000_000C, 32'h6666_0000, 1'b1, 1'b1, 1'b0);
    lookup("stall_alloc", 32'h0000_000C, 1'b0, 1'b0, 32'h0);
    resolve(PC_C, 32'h7777_0000, 1'b1, 1'b1, 1'b0);
    resolve(PC_C, 32'h7777_0000, 1'b0, 1'b1, 1'b0);
    lookup("stall_hit", PC_C, 1'b1, 1'b1, 32'h2222_0000);

    // Flush beats a same-cycle allocation and invalidates everything.
    resolve(32'h0000_0010, 32'h8888_0000, 1'b1, 1'b0, 1'b1);
    lookup("fl_new", 32'h0000_0010, 1'b0, 1'b0, 32'h0);
    lookup("fl_a", PC_A, 1'b0, 1'b0, 32'h0);
    lookup("fl_c", PC_C, 1'b0, 1'b0, 32'h0);
    lookup("fl_d", PC_D, 1'b0, 1'b0, 32'h0);

    // Retrain after flush: fresh weakly-taken counter, stale state unreachable.
    resolve(PC_A, 32'h9999_0000, 1'b1, 1'b0, 1'b0);
    resolve(PC_A, 32'h9999_0000, 1'b0, 1'b0, 1'b0);
    lookup("retrain", PC_A, 1'b1, 1'b0, 32'h9999_0000);
    resolve(PC_D, 32'hABCD_0000, 1'b1, 1'b0, 1'b0);
    lookup("retrain_d", PC_D, 1'b1, 1'b1, 32'hABCD_0000);

    // Async reset between edges, with an update pending.
    @(negedge clk);
    PC_Ex = PC_B; PC_ALU = 32'h1111_0000; Br_Detected = 1'b1; Br_Taken = 1'b1;
    PC = PC_A;
    #1;
    chk("pre_rst.hit", 32'(Hit), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.hit", 32'(Hit), 32'h0);
    chk("async_rst.tgt", Target_Add, 32'h0);
    @(posedge clk);
    #1;
    Br_Detected = 1'b0; Br_Taken = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    lookup("post_rst_a", PC_A, 1'b0, 1'b0, 32'h0);
    lookup("post_rst_b", PC_B, 1'b0, 1'b0, 32'h0);
    lookup("post_rst_d", PC_D, 1'b0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
